// File: rtl/char_pos_ctl_if.sv
// Signal bundle between the VGA timing and input side and the character position controller.
// The master drives blanking and buttons; the slave returns the sprite position.
interface char_pos_ctl_if;
  logic        vblnk;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        in_air;

  modport master (
    output vblnk, btn_left, btn_right, btn_jump,
    input  xpos, ypos, in_air
  );

  modport slave (
    input  vblnk, btn_left, btn_right, btn_jump,
    output xpos, ypos, in_air
  );
endinterface

// File: rtl/char_pos_ctl.sv
// Character sprite position controller: steps horizontally and runs a jump arc once per frame.
// Define CHAR_JUMP_EN to build the jump FSM; without it ypos stays on the ground.
module char_pos_ctl #(
  parameter int X_INIT   = 462,
  parameter int X_MAX    = 924,
  parameter int GROUND_Y = 500,
  parameter int STEP     = 4,
  parameter int JUMP_V   = 16
) (
  input  logic clk,
  input  logic rst,
  char_pos_ctl_if.slave bus
);

  logic [2:0]  btn_meta_reg;
  logic [2:0]  btn_sync_reg;
  logic        vblnk_prev_reg;
  logic        tick;
  logic        left;
  logic        right;
  logic        jump;
  logic [11:0] xpos_reg;
  logic [11:0] xpos_next;
  logic [12:0] x_wide;
  logic [12:0] x_inc;

  // Buttons are asynchronous; only the second flop stage is ever consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_reg   <= 3'b000;
      btn_sync_reg   <= 3'b000;
      vblnk_prev_reg <= 1'b0;
    end else begin
      btn_meta_reg   <= {bus.btn_jump, bus.btn_right, bus.btn_left};
      btn_sync_reg   <= btn_meta_reg;
      vblnk_prev_reg <= bus.vblnk;
    end
  end

  assign tick  = bus.vblnk && !vblnk_prev_reg;
  assign left  = btn_sync_reg[0];
  assign right = btn_sync_reg[1];
  assign jump  = btn_sync_reg[2];

  assign x_wide = {1'b0, xpos_reg};
  assign x_inc  = x_wide + 13'(STEP);

  always_comb begin
    xpos_next = xpos_reg;
    if (left && !right) begin
      xpos_next = (x_wide < 13'(STEP)) ? 12'd0 : xpos_reg - 12'(STEP);
    end else if (right && !left) begin
      xpos_next = (x_inc > 13'(X_MAX)) ? 12'(X_MAX) : x_inc[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_reg <= 12'(X_INIT);
    end else if (tick) begin
      xpos_reg <= xpos_next;
    end
  end

  assign bus.xpos = xpos_reg;

`ifdef CHAR_JUMP_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [5:0]  vel_reg;
  logic [5:0]  vel_next;
  logic [5:0]  vel_inc;
  logic [11:0] ypos_reg;
  logic [11:0] ypos_next;
  logic [12:0] y_sum;
  logic        in_air_reg;

  assign vel_inc = vel_reg + 6'd1;
  assign y_sum   = {1'b0, ypos_reg} + {7'd0, vel_inc};

  always_comb begin
    state_next = state_reg;
    vel_next   = vel_reg;
    ypos_next  = ypos_reg;
    case (state_reg)
      ST_IDLE: begin
        if (jump) begin
          state_next = ST_RISE;
          vel_next   = 6'(JUMP_V);
        end
      end
      ST_RISE: begin
        // The apex tick (vel already 0) holds position and only turns the arc around.
        if (vel_reg == 6'd0) begin
          state_next = ST_FALL;
        end else if ({1'b0, ypos_reg} < {7'd0, vel_reg}) begin
          ypos_next  = 12'd0;
          vel_next   = 6'd0;
          state_next = ST_FALL;
        end else begin
          ypos_next = ypos_reg - {6'd0, vel_reg};
          vel_next  = vel_reg - 6'd1;
        end
      end
      ST_FALL: begin
        if (y_sum >= 13'(GROUND_Y)) begin
          ypos_next  = 12'(GROUND_Y);
          vel_next   = 6'd0;
          state_next = ST_IDLE;
        end else begin
          ypos_next = y_sum[11:0];
          vel_next  = vel_inc;
        end
      end
      default: begin
        state_next = ST_IDLE;
        vel_next   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      vel_reg    <= 6'd0;
      ypos_reg   <= 12'(GROUND_Y);
      in_air_reg <= 1'b0;
    end else if (tick) begin
      state_reg  <= state_next;
      vel_reg    <= vel_next;
      ypos_reg   <= ypos_next;
      in_air_reg <= (state_next != ST_IDLE);
    end
  end

  assign bus.ypos   = ypos_reg;
  assign bus.in_air = in_air_reg;
`else
  logic unused_jump;
  assign unused_jump = jump;
  assign bus.ypos    = 12'(GROUND_Y);
  assign bus.in_air  = 1'b0;
`endif

endmodule

// File: doc/char_pos_ctl.md
CHAR_POS_CTL -- requirements
Module: char_pos_ctl

Interface
REQ-001 The block SHALL have parameter X_INIT, default 462, meaning xpos after reset.
REQ-002 The block SHALL have parameter X_MAX, default 924, meaning the largest allowed xpos (1024 minus sprite width 100).
REQ-003 The block SHALL have parameter GROUND_Y, default 500, meaning ypos at rest and after reset.
REQ-004 The block SHALL have parameter STEP, default 4, meaning horizontal pixels moved per frame.
REQ-005 The block SHALL have parameter JUMP_V, default 16, meaning initial upward velocity in pixels per frame.
REQ-006 The block SHALL have port clk, input, 1 bit: the pixel clock shared with the VGA pipeline.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port vblnk, input, 1 bit: the vertical blanking flag from the VGA timing stage.
REQ-009 The block SHALL have ports btn_left, btn_right and btn_jump, each input, 1 bit, active-high and asynchronous to clk.
REQ-010 The block SHALL have ports xpos and ypos, each output, 12 bits: the sprite top-left position consumed by the sprite-draw stage.
REQ-011 The block SHALL have port in_air, output, 1 bit: high while the jump FSM is in RISE or FALL.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer; only the synchronized values are used.
REQ-013 A frame tick SHALL be asserted for exactly one cycle when vblnk is 1 and its registered previous value is 0.
REQ-014 xpos, ypos and the FSM state SHALL change only on the clock edge following a frame tick; outputs are registered, so latency is one cycle after the tick and outputs never change during active video.
REQ-015 On a tick, left only SHALL give xpos = max(xpos-STEP, 0), right only SHALL give xpos = min(xpos+STEP, X_MAX), and both or neither SHALL leave xpos unchanged.
REQ-016 Horizontal and vertical updates SHALL be applied on the same tick, independently of each other.
REQ-017 The jump FSM SHALL have states IDLE, RISE and FALL, with a 6-bit unsigned velocity register vel.
REQ-018 In IDLE with btn_jump=1 on a tick: next state RISE, vel=JUMP_V, ypos unchanged on that tick.
REQ-019 In RISE on a tick: ypos = ypos-vel and vel = vel-1; when vel reaches 0, next state FALL.
REQ-020 In RISE, if ypos < vel, then ypos=0, vel=0 and next state FALL (top-edge clamp).
REQ-021 In FALL on a tick: vel = vel+1 and ypos = ypos+vel(new); if the result is >= GROUND_Y, then ypos=GROUND_Y, vel=0 and next state IDLE.
REQ-022 btn_jump SHALL be ignored in RISE and FALL; there is no re-trigger and no buffering.
REQ-023 All position arithmetic SHALL use 13-bit intermediates so that no underflow or overflow wraps.

Reset
REQ-024 While rst=1 at a clock edge: xpos=X_INIT, ypos=GROUND_Y, in_air=0, state=IDLE, vel=0, synchronizers and the vblnk history register cleared.
REQ-025 Reset asserted mid-jump or mid-frame SHALL take effect at the next edge; the first tick after release SHALL be the first rising vblnk edge seen with a cleared history.

Configuration
REQ-026 Macro CHAR_JUMP_EN defined: the jump FSM operates per REQ-017..022.
REQ-027 Macro CHAR_JUMP_EN undefined: FSM and vel are not built, btn_jump is ignored, ypos is constantly GROUND_Y, and in_air is constantly 0; horizontal behaviour is identical.

Verification
REQ-028 Reset, then 3 frames with no buttons -> xpos=462, ypos=500, and in_air=0 throughout.
REQ-029 btn_right held for 120 frames -> xpos increases by 4 per frame, reaches 924 at frame 116, and stays 924; then both buttons for 5 frames -> xpos stays 924.
REQ-030 btn_left held from xpos=6 -> xpos goes 2, then 0, then stays 0 with no wrap to 4094.
REQ-031 (CHAR_JUMP_EN) btn_jump pulsed across 1 tick at ground -> ypos 484 after the first RISE tick, minimum 364 after 16 RISE ticks, back to 500 after 16 FALL ticks, and in_air high for exactly 33 ticks; a second jump press mid-air has no effect.
REQ-032 rst pulsed at ypos=400 during FALL -> next edge gives ypos=500, xpos=462, in_air=0.
REQ-033 Check that xpos and ypos change only on the cycle after a rising vblnk edge, never while vblnk=0.
